// File: rtl/div_ctrl.sv
// Sequencing controller for the shared 32-bit iterative divider: operand magnitude
// conversion, start/over handshaking, sign correction, result hold and flush handling.
module div_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_signed,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        req_ready,
   input  logic        cancel,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_lo,
   output logic [31:0] res_hi,
   output logic        busy,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   output logic        div_start,
   output logic        div_busbusy,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   input  logic        div_over
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DONE  = 3'd2,
      DRAIN = 3'd3,
      ZERO  = 3'd4
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic [31:0] mag_a_reg;
   logic [31:0] mag_b_reg;
   logic [31:0] raw_a_reg;
   logic        neg_q_reg;
   logic        neg_r_reg;

   logic        accept;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] mag_a_next;
   logic [31:0] mag_b_next;
   logic [31:0] q_fixed;
   logic [31:0] r_fixed;

   assign accept = (state_reg == IDLE) & req_valid & ~cancel;
   assign a_neg  = req_signed & req_a[31];
   assign b_neg  = req_signed & req_b[31];

   // 0x80000000 negates to itself, which the divider reads as unsigned 2^31.
   assign mag_a_next = a_neg ? (32'd0 - req_a) : req_a;
   assign mag_b_next = b_neg ? (32'd0 - req_b) : req_b;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         mag_a_reg <= 32'd0;
         mag_b_reg <= 32'd0;
         raw_a_reg <= 32'd0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            mag_a_reg <= mag_a_next;
            mag_b_reg <= mag_b_next;
            raw_a_reg <= req_a;
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = (req_b == 32'd0) ? ZERO : RUN;
            end
         end
         RUN: begin
            if (cancel && div_over) begin
               state_next = IDLE;
            end else if (cancel) begin
               state_next = DRAIN;
            end else if (div_over) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (res_ready || cancel) begin
               state_next = IDLE;
            end
         end
         DRAIN: begin
            // Let the divider finish so its counter wraps cleanly to 0.
            if (div_over) begin
               state_next = IDLE;
            end
         end
         ZERO: begin
            if (res_ready || cancel) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready   = 1'b0;
      res_valid   = 1'b0;
      div_start   = 1'b0;
      div_busbusy = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
         end
         RUN: begin
            div_start   = 1'b1;
            div_busbusy = ~cancel;
         end
         DONE: begin
            div_start   = 1'b1;
            res_valid   = 1'b1;
            div_busbusy = ~(res_ready | cancel);
         end
         DRAIN: begin
            div_start = 1'b1;
         end
         ZERO: begin
            res_valid = 1'b1;
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

   assign busy  = (state_reg != IDLE);
   assign div_a = mag_a_reg;
   assign div_b = mag_b_reg;

   assign q_fixed = neg_q_reg ? (32'd0 - div_q) : div_q;
   assign r_fixed = neg_r_reg ? (32'd0 - div_r) : div_r;

   // The parked divider holds q/r, so the corrected result stays stable under backpressure.
   always_comb begin
      res_lo = 32'd0;
      res_hi = 32'd0;
      if (state_reg == DONE) begin
         res_lo = q_fixed;
         res_hi = r_fixed;
      end else if (state_reg == ZERO) begin
         res_lo = 32'hFFFF_FFFF;
         res_hi = raw_a_reg;
      end
   end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the shared 32-bit iterative divider in the execute stage. It accepts DIV/DIVU requests from the pipeline and converts signed operands to magnitudes. It runs the divider through its start/over protocol and applies sign correction to the quotient (LO) and remainder (HI). It then holds the result until the HI/LO writeback accepts it, stalls the pipeline while busy, and handles flushes without corrupting the divider's internal iteration counter.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset (also resets the divider).
- req_valid  in  1  divide request present.
- req_signed  in  1  1 = DIV (signed), 0 = DIVU.
- req_a  in  32  dividend.
- req_b  in  32  divisor.
- req_ready  out  1  request accepted when req_valid & req_ready.
- cancel  in  1  pipeline flush; kills the in-flight or pending op.
- res_valid  out  1  result available.
- res_ready  in  1  writeback accepts result.
- res_lo  out  32  quotient after sign correction.
- res_hi  out  32  remainder after sign correction.
- busy  out  1  pipeline stall request.
- div_a  out  32  divider dividend (magnitude).
- div_b  out  32  divider divisor (magnitude).
- div_start  out  1  divider start/run level.
- div_busbusy  out  1  divider hold-at-done.
- div_q  in  32  divider raw quotient.
- div_r  in  32  divider raw remainder.
- div_over  in  1  divider done flag.

## Operation
- Divider contract:
  - Operands load on the first cycle div_start is high with the counter at 0.
  - div_over rises 17 cycles later while div_start is held.
  - At done, div_busbusy=1 parks the divider with the result held. div_busbusy=0 with div_start=1 wraps its counter to 0.
  - Dropping div_start mid-run freezes the counter, so an op must never be abandoned mid-run.
- Operand latch on accept (registers, stable until return to IDLE):
  - mag_a = (req_signed & req_a[31]) ? -req_a : req_a; mag_b likewise.
  - neg_q = req_signed & (a31 ^ b31); neg_r = req_signed & a31.
  - 0x80000000 negates to itself; it is treated as unsigned magnitude 2^31.
- div_a = mag_a, div_b = mag_b.
- res_lo = neg_q ? -div_q : div_q; res_hi = neg_r ? -div_r : div_r. All 32-bit, mod 2^32.
- States:
  - IDLE: req_ready=1. req_valid & ~cancel latches operands. Goes to ZERO if req_b==0, else RUN. With cancel, the request is dropped.
  - RUN: div_start=1, div_busbusy=~cancel.
    - cancel & div_over → IDLE.
    - cancel → DRAIN.
    - div_over → DONE.
  - DONE: div_start=1, res_valid=1, div_busbusy=~(res_ready|cancel). res_ready or cancel → IDLE; the divider counter wraps to 0 in that cycle.
  - DRAIN: div_start=1, div_busbusy=0, res_valid=0. div_over → IDLE. New requests are refused until then.
  - ZERO: divider untouched. res_valid=1 with res_lo=0xFFFFFFFF and res_hi=req_a raw (no sign correction). res_ready or cancel → IDLE.
- busy = (state != IDLE).
- Control outputs req_ready, res_valid, div_start, div_busbusy and busy decode from the state register and inputs only; no combinational path from req_* to res_*.

## Timing
- Reset (rst=0 at a clock edge):
  - State is IDLE and all latched registers are 0.
  - req_ready=1; res_valid, busy, div_start and div_busbusy are 0.
  - res_lo/res_hi = 0; div_a/div_b = 0.
  - Reset mid-operation aborts immediately; the divider is reset by the same rst.
- Accept at cycle T; RUN with div_start=1 from T+1 (divider load).
- div_over at T+18; DONE and res_valid at T+19.
- Back-to-back ops: IDLE for one cycle between ops. Minimum 20 cycles per op with res_ready held high.
- ZERO path: res_valid at T+1.
- Backpressure: while res_valid & ~res_ready, res_lo/res_hi are held stable every cycle.
- Cancel in DONE or ZERO drops the result and does not complete a handshake.
- Cancel in RUN at cycle C: busy stays high until div_over + 1.
- Simultaneous res_ready & cancel counts as a cancel; writeback must ignore the result.

## Test plan
- DIVU 100/7 → res_valid at T+19; res_lo=14, res_hi=2; busy high T+1..T+19.
- DIV 0xFFFFFFF9 (−7) / 2 → res_lo=0xFFFFFFFD, res_hi=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE → res_lo=0xFFFFFFFD, res_hi=1.
- DIV 0x80000000 / 0xFFFFFFFF → res_lo=0x80000000, res_hi=0.
- DIVU 5/0 → res_valid at T+1; res_lo=0xFFFFFFFF, res_hi=5; divider div_start stays 0.
- DIVU 1000/10 with res_ready low 10 cycles after res_valid → res_lo=100, res_hi=0 stable throughout; IDLE the cycle after res_ready.
- DIVU 1000/10 with cancel at T+5 → no res_valid; req_ready low until T+19. DIVU 20/3 then offered → res_lo=6, res_hi=2, confirming clean divider restart. Reset asserted at T+8 of an op → all outputs at reset values next cycle.
